// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared condition-code encoding and defaults for the PC unit.
package pc_pkg;

  typedef enum logic [2:0] {
    EQ = 3'd0,
    NE = 3'd1,
    LT = 3'd2,
    GE = 3'd3,
    CS = 3'd4,
    CC = 3'd5,
    AL = 3'd6,
    NV = 3'd7
  } cond_e;

  localparam int RESET_VEC_DEFAULT = 0;

  function automatic logic cond_true(input cond_e cond, input logic zero, input logic neg,
                                     input logic carry);
    logic res;
    res = 1'b0;
    case (cond)
      EQ: res = zero;
      NE: res = ~zero;
      LT: res = neg;
      GE: res = ~neg;
      CS: res = carry;
      CC: res = ~carry;
      AL: res = 1'b1;
      NV: res = 1'b0;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - control/flag strobes in, fetch address and RAS status out.
interface pc_unit_if #(
  parameter int ADDR_W = 16
);
  logic              inc_en;
  logic              pc_write;
  logic              br_en;
  logic [2:0]        br_cond;
  logic              zero;
  logic              neg;
  logic              carry;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_out;
  logic              redirect;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_ovf;
  logic              ras_unf;

  modport master (
    output inc_en, pc_write, br_en, br_cond, zero, neg, carry, call, ret, target,
    input  pc_out, redirect, ras_empty, ras_full, ras_ovf, ras_unf
  );

  modport slave (
    input  inc_en, pc_write, br_en, br_cond, zero, neg, carry, call, ret, target,
    output pc_out, redirect, ras_empty, ras_full, ras_ovf, ras_unf
  );
endinterface

// File: rtl/pc_unit_ras_stack.sv
// rtl/pc_unit_ras_stack.sv - circular return-address LIFO; a push when full
// overwrites the oldest entry and keeps the count saturated.
module ras_stack #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full,
  output logic         ovf_evt,
  output logic         unf_evt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] top_ptr;
  logic [PW-1:0] next_ptr;
  logic [CW-1:0] count;

  // wr_ptr names the next free slot, so the top lives one slot behind it.
  assign top_ptr  = (wr_ptr == '0) ? LAST_PTR : wr_ptr - 1'b1;
  assign next_ptr = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
  assign top      = mem[top_ptr];
  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign ovf_evt  = push & full;
  assign unf_evt  = pop & ~push & empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= next_ptr;
      if (!full) count <= count + 1'b1;
    end else if (pop && !empty) begin
      wr_ptr <= top_ptr;
      count  <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with priority load mux, branch conditions,
// return-address stack and sticky stack-error flags.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter int                INC       = 1,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEFAULT),
  parameter int                RAS_DEPTH = 4
) (
  input logic       clk,
  input logic       reset,
  pc_unit_if.slave  bus
);
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] pc_seq;
  logic [ADDR_W-1:0] ras_top;
  logic              redirect;
  logic              redirect_next;
  logic              ovf;
  logic              unf;
  logic              do_call;
  logic              do_ret;
  logic              taken;
  logic              ras_empty;
  logic              ras_full;
  logic              ovf_evt;
  logic              unf_evt;

  // call together with ret is illegal and must leave the stack untouched.
  assign do_call = bus.call & ~bus.ret;
  assign do_ret  = bus.ret & ~bus.call;
  assign pc_seq  = pc + ADDR_W'(INC);
  assign taken   = bus.pc_write |
                   (bus.br_en & cond_true(cond_e'(bus.br_cond), bus.zero, bus.neg, bus.carry));

  ras_stack #(
    .W     (ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (do_call),
    .pop       (do_ret),
    .push_data (pc_seq),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .ovf_evt   (ovf_evt),
    .unf_evt   (unf_evt)
  );

  always_comb begin
    pc_next       = pc;
    redirect_next = 1'b0;
    if (bus.call && bus.ret) begin
      redirect_next = redirect;
    end else if (do_ret) begin
      if (!ras_empty) begin
        pc_next       = ras_top;
        redirect_next = 1'b1;
      end
    end else if (do_call || taken) begin
      pc_next       = bus.target;
      redirect_next = 1'b1;
    end else if (bus.inc_en) begin
      pc_next = pc_seq;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_VEC;
      redirect <= 1'b0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else begin
      pc       <= pc_next;
      redirect <= redirect_next;
      if (ovf_evt) ovf <= 1'b1;
      if (unf_evt) unf <= 1'b1;
    end
  end

  assign bus.pc_out    = pc;
  assign bus.redirect  = redirect;
  assign bus.ras_empty = ras_empty;
  assign bus.ras_full  = ras_full;
  assign bus.ras_ovf   = ovf;
  assign bus.ras_unf   = unf;
endmodule
